// File: rtl/piradip_gain_sched_pkg.sv
// Shared types for the AXI4-Stream gain scheduler: FSM states, table entry
// layout and the unity-gain helper.
package piradip_gain_sched_pkg;

    localparam int SCHED_GAIN_WIDTH  = 16;
    localparam int SCHED_DWELL_WIDTH = 16;

    typedef enum logic {
        IDLE,
        RUN
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_GAIN_WIDTH-1:0]  gain;
        logic [SCHED_DWELL_WIDTH-1:0] dwell;
    } sched_entry_t;

    function automatic logic [SCHED_GAIN_WIDTH-1:0] unity_gain(input int frac_width);
        return SCHED_GAIN_WIDTH'(1) << frac_width;
    endfunction

endpackage

// File: rtl/piradip_gain_sched_table.sv
// Schedule table: N_ENTRIES x sched_entry_t register file with synchronous
// write and combinational read, so a same-cycle load sees the old contents.
module piradip_gain_sched_table
    import piradip_gain_sched_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_addr,
    input  sched_entry_t       wr_data,
    input  logic [IDX_W-1:0]   rd_addr,
    output sched_entry_t       rd_data
);

    sched_entry_t mem [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/piradip_axis_gain_scheduler.sv
// Steps an AXI4-Stream gain block through a (gain, dwell) table on packet
// boundaries. Define PIRADIP_GAIN_SCHED_RAMP_EN to ramp gain per beat instead.
module piradip_axis_gain_scheduler
    import piradip_gain_sched_pkg::*;
#(
    parameter int GAIN_WIDTH       = 16,
    parameter int FRACTIONAL_WIDTH = 8,
    parameter int N_ENTRIES        = 8,
    parameter int DWELL_WIDTH      = 16,
    parameter int RAMP_STEP        = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    input  logic                          cfg_we,
    input  logic [$clog2(N_ENTRIES)-1:0]  cfg_addr,
    input  logic [GAIN_WIDTH-1:0]         cfg_gain,
    input  logic [DWELL_WIDTH-1:0]        cfg_dwell,
    input  logic [$clog2(N_ENTRIES)-1:0]  last_index,
    input  logic                          loop_en,
    input  logic                          start,
    input  logic                          stop,
    output logic [GAIN_WIDTH-1:0]         gain_out,
    output logic                          gain_update,
    output logic                          busy,
    output logic [$clog2(N_ENTRIES)-1:0]  cur_index,
    output logic                          done
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(FRACTIONAL_WIDTH));

    sched_state_t            state, next_state;
    logic [DWELL_WIDTH-1:0]  cnt;
    logic [IDX_W-1:0]        load_idx;
    logic                    load, cnt_dec, done_set, boundary;
    sched_entry_t            wr_entry, rd_entry;
    logic [GAIN_WIDTH-1:0]   new_gain;

    assign boundary = mon_tvalid & mon_tready & mon_tlast;
    assign busy     = (state == RUN);
    assign new_gain = GAIN_WIDTH'(rd_entry.gain);

    assign wr_entry.gain  = SCHED_GAIN_WIDTH'(cfg_gain);
    assign wr_entry.dwell = SCHED_DWELL_WIDTH'(cfg_dwell);

    piradip_gain_sched_table #(
        .N_ENTRIES (N_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk     (clk),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (wr_entry),
        .rd_addr (load_idx),
        .rd_data (rd_entry)
    );

    // Stop outranks start; a dwell of 0 or 1 both advance on the first boundary.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_idx   = '0;
        cnt_dec    = 1'b0;
        done_set   = 1'b0;
        if (stop) begin
            next_state = IDLE;
        end else if (start) begin
            next_state = RUN;
            load       = 1'b1;
        end else if (state == RUN && boundary) begin
            if (cnt > DWELL_WIDTH'(1)) begin
                cnt_dec = 1'b1;
            end else if (cur_index < last_index) begin
                load     = 1'b1;
                load_idx = cur_index + IDX_W'(1);
            end else if (loop_en) begin
                load = 1'b1;
            end else begin
                next_state = IDLE;
                done_set   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_index <= '0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= done_set;
            if (load) begin
                cur_index <= load_idx;
                cnt       <= DWELL_WIDTH'(rd_entry.dwell);
            end else if (cnt_dec) begin
                cnt <= cnt - DWELL_WIDTH'(1);
            end
        end
    end

`ifdef PIRADIP_GAIN_SCHED_RAMP_EN
    localparam logic signed [GAIN_WIDTH:0] STEP_EXT = (GAIN_WIDTH+1)'(RAMP_STEP);
    localparam logic [GAIN_WIDTH-1:0]      STEP     = GAIN_WIDTH'(RAMP_STEP);

    logic [GAIN_WIDTH-1:0]        target, tgt_eff, ramp_next;
    logic signed [GAIN_WIDTH:0]   g_ext, t_ext, dist;
    logic                         up, beat;

    assign beat = mon_tvalid & mon_tready;

    // A stop freezes the ramp by retargeting to the present gain.
    always_comb begin
        tgt_eff = target;
        if (load) begin
            tgt_eff = new_gain;
        end else if (stop) begin
            tgt_eff = gain_out;
        end
        g_ext     = {gain_out[GAIN_WIDTH-1], gain_out};
        t_ext     = {tgt_eff[GAIN_WIDTH-1], tgt_eff};
        up        = (t_ext > g_ext);
        dist      = up ? (t_ext - g_ext) : (g_ext - t_ext);
        ramp_next = tgt_eff;
        if (dist > STEP_EXT) begin
            ramp_next = up ? (gain_out + STEP) : (gain_out - STEP);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gain_out    <= UNITY;
            target      <= UNITY;
            gain_update <= 1'b0;
        end else begin
            target      <= tgt_eff;
            gain_update <= 1'b0;
            if (beat && (gain_out != tgt_eff)) begin
                gain_out    <= ramp_next;
                gain_update <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gain_out    <= UNITY;
            gain_update <= 1'b0;
        end else begin
            gain_update <= 1'b0;
            if (load) begin
                gain_out    <= new_gain;
                gain_update <= (new_gain != gain_out);
            end
        end
    end
`endif

endmodule

// File: tb/tb_piradip_axis_gain_scheduler.sv
// Directed self-checking bench for piradip_axis_gain_scheduler; the ramp
// scenario runs instead when PIRADIP_GAIN_SCHED_RAMP_EN is defined.
module tb_piradip_axis_gain_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mon_tvalid, mon_tready, mon_tlast;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_gain, cfg_dwell;
    logic [2:0]  last_index;
    logic        loop_en, start, stop;
    logic [15:0] gain_out;
    logic        gain_update, busy, done;
    logic [2:0]  cur_index;

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;
    int done_ref;

    logic [15:0] exp_g_one [6] = '{16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'h0080, 16'h0080};
    logic [2:0]  exp_i_one [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
    logic [15:0] exp_g_loop[8] = '{16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h0200};
    logic [2:0]  exp_i_loop[8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1};

    piradip_axis_gain_scheduler #(
        .GAIN_WIDTH       (16),
        .FRACTIONAL_WIDTH (8),
        .N_ENTRIES        (8),
        .DWELL_WIDTH      (16),
        .RAMP_STEP        ('h40)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mon_tvalid  (mon_tvalid),
        .mon_tready  (mon_tready),
        .mon_tlast   (mon_tlast),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_gain    (cfg_gain),
        .cfg_dwell   (cfg_dwell),
        .last_index  (last_index),
        .loop_en     (loop_en),
        .start       (start),
        .stop        (stop),
        .gain_out    (gain_out),
        .gain_update (gain_update),
        .busy        (busy),
        .cur_index   (cur_index),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && done) done_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [15:0] g, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_gain = g; cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input bit do_start, input bit do_stop);
        start = do_start; stop = do_stop;
        tick();
        start = 1'b0; stop = 1'b0;
    endtask

    // One packet of 'beats' beats; optionally drops TREADY or writes the table on the TLAST beat.
    task automatic applyStimulus(input int beats, input bit ready_last, input bit wr_last,
                                 input logic [2:0] wa, input logic [15:0] wg, input logic [15:0] wd);
        for (int b = 0; b < beats; b++) begin
            mon_tvalid = 1'b1;
            mon_tlast  = (b == beats - 1);
            mon_tready = (b == beats - 1) ? ready_last : 1'b1;
            if (b == beats - 1 && wr_last) begin
                cfg_we = 1'b1; cfg_addr = wa; cfg_gain = wg; cfg_dwell = wd;
            end
            tick();
        end
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic packet();
        applyStimulus(8, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
    endtask

    initial begin
        resetn = 1'b0;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_gain = '0; cfg_dwell = '0;
        last_index = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        checkOutput("reset gain_out", gain_out, 16'h0100);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cur_index", cur_index, 0);
        checkOutput("reset gain_update", gain_update, 0);
        checkOutput("reset done", done, 0);

`ifdef PIRADIP_GAIN_SCHED_RAMP_EN
        write_entry(3'd0, 16'h0200, 16'd5);
        last_index = 3'd0; loop_en = 1'b1;
        pulse(1'b1, 1'b0);
        checkOutput("ramp no step without beat", gain_out, 16'h0100);
        begin
            logic [15:0] rg [5] = '{16'h0140, 16'h0180, 16'h01C0, 16'h0200, 16'h0200};
            logic        ru [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                applyStimulus(1, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
                mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
                tick();
                mon_tvalid = 1'b0; mon_tready = 1'b0;
                checkOutput($sformatf("ramp beat%0d gain", 2*i+2), gain_out, (i < 2) ? rg[2*i+1] : 16'h0200);
                checkOutput($sformatf("ramp beat%0d update", 2*i+2), gain_update, (i < 2) ? ru[2*i+1] : 1'b0);
            end
        end
`else
        // Idle boundaries are ignored
        for (int p = 0; p < 20; p++) applyStimulus(4, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        checkOutput("idle pkts gain_out", gain_out, 16'h0100);
        checkOutput("idle pkts busy", busy, 0);
        checkOutput("idle pkts done count", done_count, 0);

        write_entry(3'd0, 16'h0100, 16'd2);
        write_entry(3'd1, 16'h0200, 16'd1);
        write_entry(3'd2, 16'h0080, 16'd3);
        last_index = 3'd2; loop_en = 1'b0;

        pulse(1'b1, 1'b0);
        checkOutput("oneshot start busy", busy, 1);
        checkOutput("oneshot start gain", gain_out, 16'h0100);
        checkOutput("oneshot start no update", gain_update, 0);
        for (int p = 0; p < 6; p++) begin
            packet();
            checkOutput($sformatf("oneshot pkt%0d gain", p + 1), gain_out, exp_g_one[p]);
            checkOutput($sformatf("oneshot pkt%0d index", p + 1), cur_index, exp_i_one[p]);
            checkOutput($sformatf("oneshot pkt%0d done", p + 1), done, (p == 5));
            if (p == 1 || p == 2)
                checkOutput($sformatf("oneshot pkt%0d update", p + 1), gain_update, 1);
        end
        checkOutput("oneshot end busy", busy, 0);
        tick();
        checkOutput("oneshot done one cycle", done, 0);
        checkOutput("oneshot done count", done_count, 1);

        loop_en = 1'b1;
        pulse(1'b1, 1'b0);
        checkOutput("loop start gain", gain_out, 16'h0100);
        checkOutput("loop start update", gain_update, 1);
        for (int p = 0; p < 8; p++) begin
            packet();
            checkOutput($sformatf("loop pkt%0d gain", p + 1), gain_out, exp_g_loop[p]);
            checkOutput($sformatf("loop pkt%0d index", p + 1), cur_index, exp_i_loop[p]);
            checkOutput($sformatf("loop pkt%0d busy", p + 1), busy, 1);
        end
        checkOutput("loop done count", done_count, 1);

        done_ref = done_count;
        pulse(1'b0, 1'b1);
        checkOutput("stop busy", busy, 0);
        for (int p = 0; p < 5; p++) packet();
        checkOutput("stop hold gain", gain_out, 16'h0200);
        checkOutput("stop hold index", cur_index, 1);
        checkOutput("stop no done", done_count, done_ref);

        pulse(1'b1, 1'b1);
        checkOutput("start+stop busy", busy, 0);
        checkOutput("start+stop gain", gain_out, 16'h0200);

        pulse(1'b1, 1'b0);
        packet();
        packet();
        checkOutput("restart setup index", cur_index, 1);
        pulse(1'b1, 1'b0);
        checkOutput("restart gain", gain_out, 16'h0100);
        checkOutput("restart index", cur_index, 0);
        checkOutput("restart update", gain_update, 1);
        packet();
        checkOutput("restart dwell reloaded", cur_index, 0);

        write_entry(3'd0, 16'h0100, 16'd0);
        pulse(1'b1, 1'b0);
        packet();
        checkOutput("dwell0 index", cur_index, 1);
        checkOutput("dwell0 gain", gain_out, 16'h0200);

        applyStimulus(8, 1'b1, 1'b1, 3'd2, 16'h0300, 16'd5);
        checkOutput("rbw index", cur_index, 2);
        checkOutput("rbw old gain", gain_out, 16'h0080);

        for (int p = 0; p < 3; p++) applyStimulus(8, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        checkOutput("tready0 index", cur_index, 2);
        checkOutput("tready0 gain", gain_out, 16'h0080);
        packet();
        packet();
        checkOutput("old dwell index", cur_index, 2);
        packet();
        checkOutput("wrap index", cur_index, 0);
        checkOutput("wrap gain", gain_out, 16'h0100);
        packet();
        packet();
        checkOutput("new entry index", cur_index, 2);
        checkOutput("new entry gain", gain_out, 16'h0300);

        resetn = 1'b0;
        #2;
        checkOutput("async reset gain", gain_out, 16'h0100);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset index", cur_index, 0);
        resetn = 1'b1;
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piradip_axis_gain_scheduler.md
Name: piradip_axis_gain_scheduler

Overview:
Sequences the gain applied by an AXI4-Stream gain block through a programmable table of (gain, dwell) entries. Snoops the stream handshake and changes gain only on packet boundaries (TLAST beats). Dwell is counted in packets. Sits beside the gain block in the stream clock domain; the gain output drives the gain block's gain input.

Parameters:
GAIN_WIDTH, 16, gain word width (signed fixed point)
FRACTIONAL_WIDTH, 8, fractional bits; unity gain = 1 << FRACTIONAL_WIDTH (0x0100)
N_ENTRIES, 8, schedule table depth (power of 2, >= 2)
DWELL_WIDTH, 16, packet-count width per entry
RAMP_STEP, 16, per-beat gain increment when the ramp option is enabled

Ports:
clk  in  1  stream clock
resetn  in  1  asynchronous active-low reset
mon_tvalid  in  1  snooped stream TVALID
mon_tready  in  1  snooped stream TREADY
mon_tlast  in  1  snooped stream TLAST
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(N_ENTRIES)  table index
cfg_gain  in  GAIN_WIDTH  entry gain
cfg_dwell  in  DWELL_WIDTH  entry dwell in packets
last_index  in  $clog2(N_ENTRIES)  final entry used
loop_en  in  1  1 = wrap to entry 0 after last_index; 0 = one-shot
start  in  1  pulse: begin schedule at entry 0
stop  in  1  pulse: halt, hold current gain
gain_out  out  GAIN_WIDTH  gain to datapath
gain_update  out  1  one-cycle strobe when gain_out changes value
busy  out  1  FSM in RUN
cur_index  out  $clog2(N_ENTRIES)  active entry
done  out  1  one-cycle pulse at one-shot completion

Behaviour:
- Reset values: gain_out = unity (0x0100), gain_update = 0, busy = 0, cur_index = 0, done = 0, dwell counter = 0. Table contents are not reset; software must write them before start.
- Boundary event: mon_tvalid & mon_tready & mon_tlast in the same cycle.
- FSM states: IDLE, RUN.
- IDLE + start -> RUN.
  - Loads entry 0: gain_out <= gain[0], cnt <= dwell[0], cur_index <= 0.
  - gain_update pulses on the next cycle.
- RUN + boundary:
  - If cnt > 1: cnt decrements.
  - If cnt <= 1: advance the index.
- Index advance:
  - idx < last_index: load entry idx+1.
  - idx == last_index and loop_en: load entry 0.
  - idx == last_index and !loop_en: go to IDLE, gain_out holds, done pulses 1 cycle.
- Latency: gain_out is registered and valid the cycle after the boundary handshake, so it applies from the first beat of the next packet.
- dwell = 0 is treated as 1.
- gain_update asserts only when the new gain differs from the old gain.
- RUN + stop -> IDLE; gain_out holds its value; no done pulse.
- start and stop in the same cycle: stop wins.
- start while in RUN: restart at entry 0 (reload; same latency).
- cfg write to the entry being loaded in the same cycle: the load reads the old contents (read-before-write). The new value takes effect on the next load.
- Writes in any state are permitted.
- last_index and loop_en are sampled at each advance. Changing them mid-run is legal.
- Boundaries in IDLE are ignored.
- Non-TLAST handshakes never change state.
- Reset mid-run: immediate return to the reset values above.

Optional Feature:
PIRADIP_GAIN_SCHED_RAMP_EN.
- Defined: a load sets a target register. gain_out moves toward the target by RAMP_STEP on each stream handshake beat, not on idle cycles. The final step clamps to the target, so there is no overshoot.
- Ramp behaviour: gain_update strobes on every step. A new load mid-ramp retargets from the current gain_out.
- Undefined: step change exactly as in Behaviour; the ramp logic is absent.

Decomposition:
- Package piradip_gain_sched_pkg holds:
  - enum sched_state_t {IDLE, RUN};
  - typedef sched_entry_t {gain, dwell};
  - function unity_gain(FRACTIONAL_WIDTH).
- One sub-module, piradip_gain_sched_table: N_ENTRIES x sched_entry_t register file, synchronous write, combinational read, read-before-write.
- FSM, counter and ramp logic live in the top.

Test Plan:
- Reset, no start: gain_out = 0x0100, busy = 0; 20 TLAST packets cause no change.
- Program gains {0x0100, 0x0200, 0x0080}, dwell {2, 1, 3}, last_index = 2, loop_en = 0, start, send 8-beat packets with TLAST on beat 8.
  - gain_out steps 0x0100 -> 0x0200 after packet 2 -> 0x0080 after packet 3.
  - done pulses after packet 6; busy = 0; gain_out stays 0x0080.
- Same table with loop_en = 1: after packet 6, cur_index = 0 and gain_out = 0x0100; the sequence repeats.
- stop mid-entry 1, then 5 packets: gain_out holds 0x0200, done never asserts.
- start and stop in the same cycle: FSM stays IDLE.
- start during RUN: reloads entry 0 one cycle later.
- Edge cases:
  - dwell = 0 entry advances after 1 packet.
  - cfg write to the next entry's address on the boundary cycle: the old gain is loaded.
  - TLAST with tready = 0 is not counted.
- RAMP_EN, RAMP_STEP = 0x40, load 0x0100 -> 0x0200: gain_out goes 0x0140, 0x0180, 0x01C0, 0x0200 on 4 handshake beats, then holds.
